// File: rtl/dcache_2way_if.sv
// Bundle of MEM-stage request/response and SRAM-controller signals for the data cache.
// master = the surrounding system (pipeline + controller), slave = the cache itself.
interface dcache_2way_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [17:0] sram_addr;
  logic [31:0] sram_write_data;
  logic [63:0] sram_read_data;
  logic        sram_ready;

  modport master (
    output rd_en, wr_en, addr, write_data, sram_read_data, sram_ready,
    input  read_data, ready, sram_rd_en, sram_wr_en, sram_addr, sram_write_data
  );

  modport slave (
    input  rd_en, wr_en, addr, write_data, sram_read_data, sram_ready,
    output read_data, ready, sram_rd_en, sram_wr_en, sram_addr, sram_write_data
  );
endinterface

// File: rtl/dcache_2way.sv
// Two-way set-associative write-through, no-write-allocate data cache:
// 64 sets x 2 ways x 64-bit lines, one LRU bit per set, combinational hit path.
module dcache_2way (
  input  logic         clk,
  input  logic         rst,
  dcache_2way_if.slave bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_MISS = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [63:0] r_lru;

  logic [5:0]  w_index;
  logic [9:0]  w_tag;
  logic        w_off;
  logic [1:0]  w_hit;
  logic [1:0]  w_vld;
  logic [1:0]  w_line_we;
  logic [63:0] w_blk [0:1];
  logic        w_hit_any;
  logic        w_hit_way;
  logic        w_victim;
  logic        w_rd_req;
  logic        w_rd_hit;
  logic        w_fill_done;
  logic        w_wr_done;
  logic [63:0] w_hit_blk;
  logic [31:0] w_hit_word;
  logic [31:0] w_fill_word;
  logic        w_unused_addr;

  assign w_index       = bus.addr[8:3];
  assign w_tag         = bus.addr[18:9];
  assign w_off         = bus.addr[2];
  assign w_unused_addr = ^{bus.addr[31:19], bus.addr[1:0]};

  assign w_rd_req    = bus.rd_en & ~bus.wr_en;
  assign w_hit_any   = |w_hit;
  assign w_hit_way   = w_hit[1];
  assign w_rd_hit    = (r_state == S_IDLE) && w_rd_req && w_hit_any;
  assign w_fill_done = (r_state == S_RD_MISS) && bus.sram_ready;
  assign w_wr_done   = (r_state == S_WRITE) && bus.sram_ready;

  // Fill the first empty way before displacing anything; otherwise follow LRU.
  assign w_victim = !w_vld[0] ? 1'b0 :
                    !w_vld[1] ? 1'b1 : r_lru[w_index];

  assign w_hit_blk   = w_hit_way ? w_blk[1] : w_blk[0];
  assign w_hit_word  = w_off ? w_hit_blk[63:32] : w_hit_blk[31:0];
  assign w_fill_word = w_off ? bus.sram_read_data[63:32] : bus.sram_read_data[31:0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      logic [9:0]  r_tag  [0:63];
      logic [63:0] r_data [0:63];
      logic [63:0] r_valid;
      logic        w_fill;
      logic        w_upd;
      logic [63:0] w_din;

      assign w_vld[gi] = r_valid[w_index];
      assign w_blk[gi] = r_data[w_index];
      assign w_hit[gi] = r_valid[w_index] && (r_tag[w_index] == w_tag);

      assign w_fill        = w_fill_done && (w_victim == 1'(gi));
      assign w_upd         = w_wr_done && w_hit[gi];
      assign w_line_we[gi] = w_fill | w_upd;
      // Store hits merge the new word into the current line so one write port suffices.
      assign w_din = w_fill ? bus.sram_read_data :
                     (w_off ? {bus.write_data, w_blk[gi][31:0]}
                            : {w_blk[gi][63:32], bus.write_data});

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_valid <= '0;
        end else if (w_fill) begin
          r_valid[w_index] <= 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (w_fill) begin
          r_tag[w_index] <= w_tag;
        end
      end

      always_ff @(posedge clk) begin
        if (w_line_we[gi]) begin
          r_data[w_index] <= w_din;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_lru   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_rd_hit || (w_wr_done && w_hit_any)) begin
        r_lru[w_index] <= ~w_hit_way;
      end else if (w_fill_done) begin
        r_lru[w_index] <= ~w_victim;
      end
    end
  end

  assign bus.sram_write_data = bus.write_data;

  always_comb begin
    w_state_next   = r_state;
    bus.ready      = 1'b0;
    bus.read_data  = 32'd0;
    bus.sram_rd_en = 1'b0;
    bus.sram_wr_en = 1'b0;
    bus.sram_addr  = 18'd0;
    case (r_state)
      S_IDLE: begin
        bus.ready = !(bus.rd_en || bus.wr_en) || w_rd_hit;
        if (w_rd_hit) begin
          bus.read_data = w_hit_word;
        end
        if (bus.wr_en) begin
          w_state_next = S_WRITE;
        end else if (bus.rd_en && !w_hit_any) begin
          w_state_next = S_RD_MISS;
        end
      end
      S_RD_MISS: begin
        bus.sram_rd_en = 1'b1;
        bus.sram_addr  = {bus.addr[18:3], 2'b00};
        if (bus.sram_ready) begin
          bus.ready     = 1'b1;
          bus.read_data = w_fill_word;
          w_state_next  = S_IDLE;
        end
      end
      S_WRITE: begin
        bus.sram_wr_en = 1'b1;
        bus.sram_addr  = {bus.addr[18:2], 1'b0};
        if (bus.sram_ready) begin
          bus.ready    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_2way.sv
// Scoreboard bench for dcache_2way: stimulus queues expected CPU and SRAM responses,
// separate monitor/responder processes pop and compare them.
module tb_dcache_2way;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dcache_2way_if bus ();

  dcache_2way dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       nm;
    bit          is_rd;
    logic [31:0] data;
    int          stalls;
  } cpu_exp_t;

  typedef struct {
    string       nm;
    bit          is_wr;
    logic [17:0] addr;
    logic [31:0] wdata;
  } sram_exp_t;

  cpu_exp_t    cpu_q[$];
  sram_exp_t   sram_q[$];
  logic [31:0] mem [logic [31:0]];
  int          vecs  = 0;
  int          fails = 0;

  function automatic logic [31:0] rdw(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h5000_0000 | a;
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] req);
    vecs++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // CPU-side monitor: pops an expectation whenever a pending request sees ready.
  initial begin
    int       stall;
    cpu_exp_t e;
    stall = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 0;
      end else if (bus.rd_en || bus.wr_en) begin
        if (bus.ready) begin
          if (cpu_q.size() == 0) begin
            check("unexpected_ready", 64'(cpu_q.size()), 64'd1);
          end else begin
            e = cpu_q.pop_front();
            check({e.nm, "_stalls"}, 64'(stall), 64'(e.stalls));
            if (e.is_rd) check({e.nm, "_data"}, 64'(bus.read_data), 64'(e.data));
          end
          stall = 0;
        end else begin
          stall++;
        end
      end
    end
  end

  // SRAM controller model: answers 5 cycles after the request appears.
  initial begin
    sram_exp_t   e;
    logic [17:0] a;
    logic [31:0] ba;
    bit          w;
    bit          ok;
    bus.sram_ready     = 1'b0;
    bus.sram_read_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst && (bus.sram_rd_en || bus.sram_wr_en)) begin
        check("sram_exclusive", 64'(bus.sram_rd_en & bus.sram_wr_en), 64'd0);
        a  = bus.sram_addr;
        w  = bus.sram_wr_en;
        ba = {13'd0, a, 1'b0};
        if (sram_q.size() == 0) begin
          check("unexpected_sram", 64'(sram_q.size()), 64'd1);
          e.nm = "extra"; e.is_wr = w; e.addr = a; e.wdata = bus.sram_write_data;
        end else begin
          e = sram_q.pop_front();
          check({e.nm, "_sram_kind"}, 64'(w), 64'(e.is_wr));
          check({e.nm, "_sram_addr"}, 64'(a), 64'(e.addr));
          if (e.is_wr) check({e.nm, "_sram_wdata"}, 64'(bus.sram_write_data), 64'(e.wdata));
        end
        ok = 1'b1;
        for (int i = 0; i < 4 && ok; i++) begin
          @(posedge clk);
          #2;
          if (!rst) ok = 1'b0;
          else check({e.nm, "_addr_stable"}, 64'(bus.sram_addr), 64'(a));
        end
        if (ok) begin
          @(posedge clk);
          #1;
          if (w) mem[ba] = bus.sram_write_data;
          else bus.sram_read_data = {rdw(ba + 32'd4), rdw(ba)};
          bus.sram_ready = 1'b1;
          @(posedge clk);
          #1;
          bus.sram_ready = 1'b0;
        end
      end
    end
  end

  // skind: 0 = no SRAM access expected, 1 = block read, 2 = word write.
  task automatic txn(string nm, bit rd, bit wr, logic [31:0] a, logic [31:0] wd,
                     logic [31:0] exp_d, int exp_st, int skind, logic [17:0] saddr);
    cpu_exp_t  c;
    sram_exp_t s;
    int        n;
    c.nm = nm; c.is_rd = rd && !wr; c.data = exp_d; c.stalls = exp_st;
    cpu_q.push_back(c);
    if (skind != 0) begin
      s.nm = nm; s.is_wr = (skind == 2); s.addr = saddr; s.wdata = wd;
      sram_q.push_back(s);
    end
    @(posedge clk);
    #1;
    bus.rd_en = rd; bus.wr_en = wr; bus.addr = a; bus.write_data = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready && n < 40);
    if (!bus.ready) begin
      vecs++;
      fails++;
      $display("FAIL %s_timeout: ready stayed 0, required 1", nm);
    end
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    $display("txn %-12s rd=%0b wr=%0b addr=%h wdata=%h exp=%h stalls=%0d",
             nm, rd, wr, a, wd, exp_d, exp_st);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.write_data = '0;
    mem[32'h10] = 32'hCCCC_DDDD;
    mem[32'h14] = 32'hAAAA_BBBB;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",      64'(bus.ready),      64'd1);
    check("rst_read_data",  64'(bus.read_data),  64'd0);
    check("rst_sram_rd_en", 64'(bus.sram_rd_en), 64'd0);
    check("rst_sram_wr_en", 64'(bus.sram_wr_en), 64'd0);
    check("rst_sram_addr",  64'(bus.sram_addr),  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    //  name           rd wr addr          wdata         expected      st kind sram_addr
    txn("first_miss",  1, 0, 32'h0000_0010, 32'h0,        32'hCCCC_DDDD, 6, 1, 18'h00008);
    txn("first_hit",   1, 0, 32'h0000_0014, 32'h0,        32'hAAAA_BBBB, 0, 0, 18'h0);
    txn("wr_hit",      0, 1, 32'h0000_0014, 32'h1234_5678, 32'h0,        6, 2, 18'h0000A);
    txn("wr_hit_rd",   1, 0, 32'h0000_0014, 32'h0,        32'h1234_5678, 0, 0, 18'h0);
    txn("wr_miss",     0, 1, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0,        6, 2, 18'h01000);
    txn("wr_miss_rd",  1, 0, 32'h0000_2000, 32'h0,        32'hDEAD_BEEF, 6, 1, 18'h01000);
    txn("ev_a_hit",    1, 0, 32'h0000_0010, 32'h0,        32'hCCCC_DDDD, 0, 0, 18'h0);
    txn("ev_b_miss",   1, 0, 32'h0000_0210, 32'h0,        32'h5000_0210, 6, 1, 18'h00108);
    txn("ev_c_miss",   1, 0, 32'h0000_0410, 32'h0,        32'h5000_0410, 6, 1, 18'h00208);
    txn("ev_b_hit",    1, 0, 32'h0000_0210, 32'h0,        32'h5000_0210, 0, 0, 18'h0);
    txn("ev_a_miss",   1, 0, 32'h0000_0010, 32'h0,        32'hCCCC_DDDD, 6, 1, 18'h00008);
    txn("ev_a_hi",     1, 0, 32'h0000_0014, 32'h0,        32'h1234_5678, 0, 0, 18'h0);
    txn("lru_a_miss",  1, 0, 32'h0000_0020, 32'h0,        32'h5000_0020, 6, 1, 18'h00010);
    txn("lru_b_miss",  1, 0, 32'h0000_0220, 32'h0,        32'h5000_0220, 6, 1, 18'h00110);
    txn("lru_a_hit",   1, 0, 32'h0000_0020, 32'h0,        32'h5000_0020, 0, 0, 18'h0);
    txn("lru_c_miss",  1, 0, 32'h0000_0420, 32'h0,        32'h5000_0420, 6, 1, 18'h00210);
    txn("lru_a_kept",  1, 0, 32'h0000_0024, 32'h0,        32'h5000_0024, 0, 0, 18'h0);
    txn("lru_b_gone",  1, 0, 32'h0000_0220, 32'h0,        32'h5000_0220, 6, 1, 18'h00110);
    txn("rdwr_both",   1, 1, 32'h0000_0030, 32'h0BAD_F00D, 32'h0,        6, 2, 18'h00018);
    txn("rdwr_fill",   1, 0, 32'h0000_0034, 32'h0,        32'h5000_0034, 6, 1, 18'h00018);
    txn("rdwr_hit",    1, 0, 32'h0000_0030, 32'h0,        32'h0BAD_F00D, 0, 0, 18'h0);

    // Reset in the second cycle of a read miss.
    begin
      sram_exp_t s;
      s.nm = "rst_mid"; s.is_wr = 1'b0; s.addr = 18'h0001C; s.wdata = 32'h0;
      sram_q.push_back(s);
    end
    @(posedge clk);
    #1;
    bus.rd_en = 1'b1; bus.addr = 32'h0000_0038;
    @(posedge clk);
    #2;
    check("rst_mid_in_miss", 64'(bus.sram_rd_en), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_sram_rd_en", 64'(bus.sram_rd_en), 64'd0);
    check("rst_mid_sram_addr",  64'(bus.sram_addr),  64'd0);
    bus.rd_en = 1'b0;
    #1;
    check("rst_mid_ready",     64'(bus.ready),     64'd1);
    check("rst_mid_read_data", 64'(bus.read_data), 64'd0);
    $display("txn %-12s rd=1 wr=0 addr=00000038 reset asserted in RD_MISS", "rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    txn("rst_refetch", 1, 0, 32'h0000_0038, 32'h0,        32'h5000_0038, 6, 1, 18'h0001C);
    txn("rst_cold",    1, 0, 32'h0000_0010, 32'h0,        32'hCCCC_DDDD, 6, 1, 18'h00008);

    repeat (10) @(posedge clk);
    check("cpu_queue_empty",  64'(cpu_q.size()),  64'd0);
    check("sram_queue_empty", 64'(sram_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
